munoc_idle_policy: RTL and testbench

- Downstream consumer of the per-link idle/utilization history monitor.
- The monitor delivers a packed vector of NUM_SAMPLE per-window utilization samples and a window-boundary pulse. This block sums those samples into a load figure and classifies it into a level.
- It runs a power-state FSM with hysteresis that requests sleep for the link/router domain through a req/ack handshake and exits sleep on load increase or an explicit wake event.

---
 rtl/munoc_idle_policy_if.sv | 29 ++
 rtl/munoc_idle_policy.sv | 100 ++++++++++
 tb/tb_munoc_idle_policy.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/munoc_idle_policy_if.sv
// Bundle between the idle/utilization monitor, the power controller and
// munoc_idle_policy.
//   master : the monitor / power-controller side (drives history, wake, ack)
//   slave  : munoc_idle_policy (drives sleep_req, is_sleeping, load_sum/level)
interface munoc_idle_policy_if #(
  parameter int BW_DATA   = 32,
  parameter int BW_SAMPLE = 4
);
  localparam int BW_SUM = BW_SAMPLE + 4;

  logic                sample_update;
  logic [BW_DATA-1:0]  sample_history;
  logic                wake_event;
  logic                sleep_ack;
  logic                sleep_req;
  logic                is_sleeping;
  logic [BW_SUM-1:0]   load_sum;
  logic [1:0]          load_level;

  modport master (
    output sample_update, sample_history, wake_event, sleep_ack,
    input  sleep_req, is_sleeping, load_sum, load_level
  );

  modport slave (
    input  sample_update, sample_history, wake_event, sleep_ack,
    output sleep_req, is_sleeping, load_sum, load_level
  );
endinterface

// File: rtl/munoc_idle_policy.sv
// Idle power policy for one link/router domain.
// Sums the monitor's per-window utilization samples into load_sum, classifies
// it into load_level, and runs a hysteretic sleep FSM that requests sleep via
// a sleep_req/sleep_ack level handshake.
// Ports:
//   clk, rstp : clock, asynchronous active-high reset
//   enable    : global advance enable; all state holds while low
//   bus       : slave side of munoc_idle_policy_if (history in, sleep handshake
//               and load outputs)
module munoc_idle_policy #(
  parameter int BW_DATA      = 32,
  parameter int BW_SAMPLE    = 4,
  parameter int LOW_TH       = 4,
  parameter int HIGH_TH      = 16,
  parameter int HOLD_WINDOWS = 3
) (
  input  logic               clk,
  input  logic               rstp,
  input  logic               enable,
  munoc_idle_policy_if.slave bus
);
  localparam int NUM_SAMPLE = BW_DATA / BW_SAMPLE;
  localparam int BW_SUM     = BW_SAMPLE + 4;
  localparam int BW_HOLD    = (HOLD_WINDOWS < 2) ? 1 : $clog2(HOLD_WINDOWS + 1);

  // Monitor resets its samples to all-ones, so the matching sum is the reset load.
  localparam logic [BW_SUM-1:0]  SUM_RST   = BW_SUM'(NUM_SAMPLE * ((1 << BW_SAMPLE) - 1));
  localparam logic [BW_SUM-1:0]  LOW_T     = BW_SUM'(LOW_TH);
  localparam logic [BW_SUM-1:0]  HIGH_T    = BW_SUM'(HIGH_TH);
  localparam logic [BW_HOLD-1:0] HOLD_MAX  = BW_HOLD'(HOLD_WINDOWS);
  localparam logic [BW_HOLD-1:0] HOLD_LAST = BW_HOLD'(HOLD_WINDOWS - 1);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    REQ    = 2'd1,
    SLEEP  = 2'd2,
    EXIT   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          vld_pipe;   // [0]=upd_d (history valid), [1]=sum_valid
  logic [BW_HOLD-1:0]  hold_cnt;
  logic [BW_SUM-1:0]   sum_nxt;
  logic [1:0]          lvl_nxt;
  logic                upd_d, sum_valid, idle_win, high_win;

  assign upd_d     = vld_pipe[0];
  assign sum_valid = vld_pipe[1];
  assign idle_win  = bus.load_sum < LOW_T;
  assign high_win  = bus.load_sum >= HIGH_T;

  always_comb begin
    sum_nxt = '0;
    for (int k = 0; k < NUM_SAMPLE; k++)
      sum_nxt = sum_nxt + BW_SUM'(bus.sample_history[k*BW_SAMPLE +: BW_SAMPLE]);
    if (sum_nxt >= HIGH_T)     lvl_nxt = 2'd2;
    else if (sum_nxt < LOW_T)  lvl_nxt = 2'd0;
    else                       lvl_nxt = 2'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE: if (sum_valid && idle_win && hold_cnt == HOLD_LAST && !bus.wake_event)
                state_nxt = REQ;
      // Wake beats a simultaneous ack so an aborted entry never reports sleep.
      REQ:    if (bus.wake_event)     state_nxt = EXIT;
              else if (bus.sleep_ack) state_nxt = SLEEP;
      // Mid-band loads fall through: that gap between thresholds is the hysteresis.
      SLEEP:  if (bus.wake_event || (sum_valid && high_win)) state_nxt = EXIT;
      EXIT:   if (!bus.sleep_ack)     state_nxt = ACTIVE;
      default:                        state_nxt = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      vld_pipe        <= '0;
      bus.load_sum    <= SUM_RST;
      bus.load_level  <= 2'd2;
      hold_cnt        <= '0;
      state           <= ACTIVE;
      bus.sleep_req   <= 1'b0;
      bus.is_sleeping <= 1'b0;
    end else if (enable) begin
      vld_pipe <= {vld_pipe[0], bus.sample_update};
      if (upd_d) begin
        bus.load_sum   <= sum_nxt;
        bus.load_level <= lvl_nxt;
      end
      if (state == EXIT && state_nxt == ACTIVE)
        hold_cnt <= '0;
      else if (state == ACTIVE && sum_valid)
        hold_cnt <= !idle_win ? '0 : (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
      state           <= state_nxt;
      bus.sleep_req   <= (state_nxt == REQ) || (state_nxt == SLEEP);
      bus.is_sleeping <= (state_nxt == SLEEP);
    end
  end
endmodule

// File: tb/tb_munoc_idle_policy.sv
module tb_munoc_idle_policy;
  logic clk = 1'b0;
  logic rstp = 1'b1;
  logic enable = 1'b1;

  munoc_idle_policy_if #(.BW_DATA(32), .BW_SAMPLE(4)) bus();

  munoc_idle_policy dut (
    .clk    (clk),
    .rstp   (rstp),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sum;
    logic [1:0] lvl;
  } exp_t;

  typedef struct {
    logic [31:0] hist;
    logic [7:0]  sum;
    logic [1:0]  lvl;
    logic        req;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse at cycle t; load_sum is checked in t+2; returns in t+3 where the
  // FSM decision taken on the t+2 edge is visible.
  task automatic window(input logic [31:0] hist, input logic [7:0] s, input logic [1:0] l);
    exp_t e;
    bus.sample_history = hist;
    bus.sample_update  = 1'b1;
    if (enable) sb.push_back('{sum: s, lvl: l});
    tick;
    bus.sample_update = 1'b0;
    tick;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("load_sum", 32'(bus.load_sum), 32'(e.sum));
      chk("load_level", 32'(bus.load_level), 32'(e.lvl));
    end
    tick;
  endtask

  initial begin
    tbl[0] = '{32'h0000_0011, 8'd2, 2'd0, 1'b0};
    tbl[1] = '{32'h0000_0011, 8'd2, 2'd0, 1'b0};
    tbl[2] = '{32'h0000_1111, 8'd4, 2'd1, 1'b0};
    tbl[3] = '{32'h0000_0000, 8'd0, 2'd0, 1'b0};
    tbl[4] = '{32'h0000_0000, 8'd0, 2'd0, 1'b0};
    tbl[5] = '{32'h0000_0000, 8'd0, 2'd0, 1'b1};

    bus.sample_update  = 1'b0;
    bus.sample_history = '0;
    bus.wake_event     = 1'b0;
    bus.sleep_ack      = 1'b0;

    // Reset values, then hold with no updates.
    repeat (3) tick;
    chk("rst_load_sum", 32'(bus.load_sum), 32'd120);
    chk("rst_load_level", 32'(bus.load_level), 32'd2);
    chk("rst_sleep_req", 32'(bus.sleep_req), 32'd0);
    chk("rst_is_sleeping", 32'(bus.is_sleeping), 32'd0);
    rstp = 1'b0;
    repeat (10) tick;
    chk("idle_load_sum", 32'(bus.load_sum), 32'd120);
    chk("idle_load_level", 32'(bus.load_level), 32'd2);

    // Three zero windows -> request; ack -> sleep.
    for (int i = 0; i < 3; i++) begin
      window(32'h0, 8'd0, 2'd0);
      chk("t2_sleep_req", 32'(bus.sleep_req), (i == 2) ? 32'd1 : 32'd0);
      repeat (5) tick;
    end
    chk("t2_not_sleeping", 32'(bus.is_sleeping), 32'd0);
    bus.sleep_ack = 1'b1;
    tick;
    chk("t2_is_sleeping", 32'(bus.is_sleeping), 32'd1);

    // Mid-band load while asleep keeps sleeping; high load exits.
    window(32'h1111_1111, 8'd8, 2'd1);
    chk("t4_mid_sleeping", 32'(bus.is_sleeping), 32'd1);
    chk("t4_mid_req", 32'(bus.sleep_req), 32'd1);
    window(32'h2222_2222, 8'd16, 2'd2);
    chk("t4_exit_req", 32'(bus.sleep_req), 32'd0);
    chk("t4_exit_sleeping", 32'(bus.is_sleeping), 32'd0);
    repeat (5) tick;
    chk("t4_ackhold_req", 32'(bus.sleep_req), 32'd0);
    bus.sleep_ack = 1'b0;
    tick;

    // Back in ACTIVE: hysteresis counter sequence from the table.
    for (int i = 0; i < 6; i++) begin
      window(tbl[i].hist, tbl[i].sum, tbl[i].lvl);
      chk("t3_sleep_req", 32'(bus.sleep_req), 32'(tbl[i].req));
      chk("t3_is_sleeping", 32'(bus.is_sleeping), 32'd0);
      repeat (5) tick;
    end

    // In REQ: wake together with ack aborts entry.
    bus.wake_event = 1'b1;
    bus.sleep_ack  = 1'b1;
    tick;
    chk("t5_req_drop", 32'(bus.sleep_req), 32'd0);
    chk("t5_never_sleep", 32'(bus.is_sleeping), 32'd0);
    bus.wake_event = 1'b0;
    repeat (3) tick;
    chk("t5_exit_hold", 32'(bus.is_sleeping), 32'd0);
    bus.sleep_ack = 1'b0;
    tick;

    // Re-enter sleep, then async reset mid-cycle.
    for (int i = 0; i < 3; i++) begin
      window(32'h0, 8'd0, 2'd0);
      repeat (5) tick;
    end
    chk("t6_req", 32'(bus.sleep_req), 32'd1);
    bus.sleep_ack = 1'b1;
    tick;
    chk("t6_sleeping", 32'(bus.is_sleeping), 32'd1);
    #2 rstp = 1'b1;
    #1;
    chk("t6_async_req", 32'(bus.sleep_req), 32'd0);
    chk("t6_async_sleeping", 32'(bus.is_sleeping), 32'd0);
    chk("t6_async_sum", 32'(bus.load_sum), 32'd120);
    tick;
    rstp = 1'b0;
    bus.sleep_ack = 1'b0;
    tick;

    // Update pulse while disabled is ignored.
    enable = 1'b0;
    window(32'h0, 8'd0, 2'd0);
    repeat (2) tick;
    enable = 1'b1;
    repeat (4) tick;
    chk("t6_en_sum", 32'(bus.load_sum), 32'd120);
    chk("t6_en_level", 32'(bus.load_level), 32'd2);
    chk("t6_en_req", 32'(bus.sleep_req), 32'd0);

    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
